// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: byte-wide fetch FSM with a 2-entry prefetch queue.
// It also handles jump redirects and vectored interrupts.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  INT_BASE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [15:0] addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_byte,
    output logic [15:0] instr_pc,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    input  logic        int_req,
    input  logic [7:0]  vector,
    output logic        int_ack,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, RD} state_e;
    state_e      state_q;
    logic [15:0] fetch_pc_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [7:0]  byte_q [2];
    logic [15:0] pc_q [2];
    logic        armed_q, int_ack_q;
    logic        push, pop, int_take;
    assign int_take    = state_q == IDLE && !jump_en && int_req && armed_q;
    assign push        = state_q == RD && !jump_en;
    assign pop         = instr_valid && instr_ready && !jump_en && !int_take;
    assign count_d     = count_q + {1'b0, push} - {1'b0, pop};
    assign instr_valid = count_q != 2'd0;
    assign instr_byte  = instr_valid ? byte_q[rd_ptr_q] : 8'h00;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr_q] : 16'h0000;
    assign bus_req     = state_q == REQ;
    assign mem_rd      = state_q == RD;
    assign addr        = (bus_req || mem_rd) ? fetch_pc_q : 16'h0000;
    assign busy        = state_q != IDLE;
    assign int_ack     = int_ack_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            byte_q[0]  <= 8'h00;
            byte_q[1]  <= 8'h00;
            pc_q[0]    <= 16'h0000;
            pc_q[1]    <= 16'h0000;
            armed_q    <= 1'b1;
            int_ack_q  <= 1'b0;
        end else begin
            int_ack_q <= int_take;
            // re-arm only once the interrupt line has been seen low
            armed_q   <= int_take ? 1'b0 : (armed_q || !int_req);
            if (jump_en || int_take) begin
                state_q    <= IDLE;
                count_q    <= 2'd0;
                rd_ptr_q   <= 1'b0;
                wr_ptr_q   <= 1'b0;
                fetch_pc_q <= jump_en ? jump_addr : {INT_BASE, vector};
            end else begin
                count_q <= count_d;
                if (push) begin
                    byte_q[wr_ptr_q] <= mem_data;
                    pc_q[wr_ptr_q]   <= fetch_pc_q;
                    wr_ptr_q         <= ~wr_ptr_q;
                    fetch_pc_q       <= fetch_pc_q + 16'd1;
                end
                if (pop)
                    rd_ptr_q <= ~rd_ptr_q;
                case (state_q)
                    IDLE:    state_q <= (count_q < 2'd2) ? REQ : IDLE;
                    REQ:     state_q <= bus_ack ? RD : REQ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus a randomized run scored
// against a stream model of fetched bytes.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req, bus_ack, mem_rd, instr_valid, instr_ready;
    logic [15:0] addr, instr_pc, jump_addr;
    logic [7:0]  mem_data, instr_byte, vector;
    logic        jump_en, int_req, int_ack, busy;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign mem_data = mem_fn(addr);

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_ack(bus_ack), .addr(addr),
        .mem_rd(mem_rd), .mem_data(mem_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_byte(instr_byte), .instr_pc(instr_pc),
        .jump_en(jump_en), .jump_addr(jump_addr), .int_req(int_req),
        .vector(vector), .int_ack(int_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        bus_ack = 1'b0; instr_ready = 1'b0; jump_en = 1'b0;
        jump_addr = 16'h0000; int_req = 1'b0; vector = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_ack = 1'b1; instr_ready = 1'b1; jump_en = 1'b0;
        jump_addr = 16'h0000; int_req = 1'b1; vector = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_req, mem_rd, instr_valid, int_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp 00000", {bus_req, mem_rd, instr_valid, int_ack, busy});
        end
        checks++;
        if (addr !== 16'h0000 || instr_pc !== 16'h0000 || instr_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: addr=%h pc=%h byte=%h exp 0000/0000/00", addr, instr_pc, instr_byte);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus_ack = 1'b1; instr_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (bus_req !== 1'b1 || addr !== 16'h0000) begin
                    errors++;
                    $display("FAIL basic_first_req: bus_req=%b addr=%h exp 1/0000", bus_req, addr);
                end
            end
            checks++;
            if (instr_valid !== (c % 3 == 0)) begin
                errors++;
                $display("FAIL basic_valid c=%0d: got %b exp %b", c, instr_valid, c % 3 == 0);
            end
            if (c % 3 == 0) begin
                checks++;
                if (instr_pc !== 16'(c / 3 - 1) || instr_byte !== 8'(c / 3 - 1)) begin
                    errors++;
                    $display("FAIL basic_data c=%0d: pc=%h byte=%h exp %h", c, instr_pc, instr_byte, 16'(c / 3 - 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        do_reset();
        bus_ack = 1'b1; instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (bus_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
                errors++;
                $display("FAIL bp_full: bus_req=%b busy=%b valid=%b pc=%h exp 0/0/1/0000", bus_req, busy, instr_valid, instr_pc);
            end
            @(negedge clk);
        end
        instr_ready = 1'b1;
        for (int n = 0; n < 30 && got < 3; n++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== 16'(got) || instr_byte !== 8'(got)) begin
                    errors++;
                    $display("FAIL bp_order: pc=%h byte=%h exp %h", instr_pc, instr_byte, 16'(got));
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_timeout: got %0d bytes exp 3", got);
        end
    endtask

    task automatic test_jump();
        bit done = 0;
        do_reset();
        bus_ack = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL jump_pre_req: bus_req=%b exp 1", bus_req);
        end
        jump_en = 1'b1; jump_addr = 16'h1234;
        @(negedge clk);
        jump_en = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_drop: bus_req=%b mem_rd=%b valid=%b exp 0/0/0", bus_req, mem_rd, instr_valid);
        end
        bus_ack = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (mem_rd && addr !== 16'h1234) begin
                checks++; errors++;
                $display("FAIL jump_rd_addr: addr=%h exp 1234", addr);
            end
            if (instr_valid) begin
                done = 1;
                checks++;
                if (instr_pc !== 16'h1234 || instr_byte !== 8'h26) begin
                    errors++;
                    $display("FAIL jump_target: pc=%h byte=%h exp 1234/26", instr_pc, instr_byte);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL jump_timeout: got no byte exp 1");
        end
    endtask

    task automatic test_jump_pop_wrap();
        int got = 0;
        logic [15:0] exp_pc [2];
        exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000;
        do_reset();
        bus_ack = 1'b1; instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 16'hFFFF;
        @(negedge clk);
        jump_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_pop_flush: valid=%b exp 0", instr_valid);
        end
        for (int n = 0; n < 30 && got < 2; n++) begin
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc[got] || instr_byte !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_pc: pc=%h byte=%h exp %h/00", instr_pc, instr_byte, exp_pc[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d bytes exp 2", got);
        end
    endtask

    task automatic test_interrupt();
        int pulses = 0;
        bit first = 0;
        do_reset();
        bus_ack = 1'b1; instr_ready = 1'b0; vector = 8'h38;
        repeat (10) @(negedge clk);
        int_req = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (int_ack) begin
                pulses++;
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL int_flush: valid=%b exp 0", instr_valid);
                end
            end
            if (!first && instr_valid && instr_ready) begin
                first = 1;
                checks++;
                if (instr_pc !== 16'h0038 || instr_byte !== 8'h38) begin
                    errors++;
                    $display("FAIL int_target: pc=%h byte=%h exp 0038/38", instr_pc, instr_byte);
                end
            end
            if (pulses > 0) instr_ready = 1'b1;
        end
        int_req = 1'b0;
        checks++;
        if (pulses != 1 || !first) begin
            errors++;
            $display("FAIL int_pulse: pulses=%0d delivered=%0d exp 1/1", pulses, first);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_ack = 1'b1; instr_ready = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: mem_rd=%b valid=%b exp 1/1", mem_rd, instr_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus_req, mem_rd, instr_valid, busy} !== 4'b0 || addr !== 16'h0000) begin
            errors++;
            $display("FAIL arst_abort: ctl=%b addr=%h exp 0000/0000", {bus_req, mem_rd, instr_valid, busy}, addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_pc = 16'h0000;
        logic [15:0] prev_pc = 16'h0000;
        logic [7:0]  prev_byte = 8'h00;
        bit          prev_stall = 0;
        bit          prev_ack = 0;
        do_reset();
        vector = 8'hA5;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (int_ack) begin
                exp_pc = {8'h00, vector};
                checks++;
                if (prev_ack) begin
                    errors++;
                    $display("FAIL rnd_ack_pulse n=%0d: int_ack high two cycles exp one", n);
                end
            end
            if (prev_stall && !int_ack) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_byte !== prev_byte) begin
                    errors++;
                    $display("FAIL rnd_stable n=%0d: valid=%b pc=%h byte=%h exp 1/%h/%h", n, instr_valid, instr_pc, instr_byte, prev_pc, prev_byte);
                end
            end
            if (!bus_req && !mem_rd) begin
                checks++;
                if (addr !== 16'h0000) begin
                    errors++;
                    $display("FAIL rnd_addr_idle n=%0d: addr=%h exp 0000", n, addr);
                end
            end
            bus_ack = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) != 0;
            jump_en = ($urandom % 25) == 0;
            jump_addr = (($urandom % 4) == 0) ? 16'hFFFE : 16'($urandom);
            if (($urandom % 20) == 0) int_req = ~int_req;
            if (instr_valid && instr_ready && !jump_en) begin
                checks++;
                if (instr_pc !== exp_pc || instr_byte !== mem_fn(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_stream n=%0d: pc=%h byte=%h exp %h/%h", n, instr_pc, instr_byte, exp_pc, mem_fn(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
            end
            if (jump_en) exp_pc = jump_addr;
            prev_stall = instr_valid && !instr_ready && !jump_en;
            prev_pc = instr_pc;
            prev_byte = instr_byte;
            prev_ack = int_ack;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_jump();
        test_jump_pop_wrap();
        test_interrupt();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
